iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
Multi-cycle, parametrised shift unit for the execute stage. It generalises the fixed left-shift-by-2 immediate path to a variable shift amount and four modes: logical left, logical right, arithmetic right and rotate right. The shift runs iteratively, at most STEP bit positions per cycle, which keeps the shifter small. It uses valid/ready handshakes on both input and output, and a pipeline flush aborts an operation in flight.

Parameters:
- WIDTH, 32: operand and result width in bits; power of 2, at least 8.
- STEP, 8: maximum bit positions shifted per cycle; power of 2, between 1 and WIDTH.
- SHAMT_W, $clog2(WIDTH): width of the shift-amount field (derived).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: abort the current operation and discard it.
- in_valid, in, 1: request valid.
- in_ready, out, 1: unit can accept a request.
- in_mode, in, 2: operation select; 0 SLL, 1 SRL, 2 SRA, 3 ROR.
- in_operand, in, WIDTH: value to shift.
- in_shamt, in, SHAMT_W: shift amount, interpreted modulo WIDTH.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_result, out, WIDTH: shifted value.
- busy, out, 1: high in BUSY or DONE.

Behaviour:
- Reset: state IDLE; out_valid=0; out_result=0; busy=0; in_ready=1 from the first cycle after reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: shifting.
  - DONE: out_valid=1, result held stable.
- in_ready is high only in IDLE. There is no accept while in BUSY or DONE.
- Accept: in IDLE with in_valid=1 and flush=0, the unit latches operand, mode and remaining=in_shamt, and moves to BUSY.
- BUSY, each cycle:
  - step = min(remaining, STEP).
  - The working register is shifted by step in the latched mode.
  - remaining decrements by step.
  - When the updated remaining is 0, the working value is copied to out_result and the state moves to DONE.
- Latency: N = max(1, ceil(shamt/STEP)) BUSY cycles. out_valid rises N edges after the accept edge.
  - shamt=0 takes 1 cycle and returns the operand unchanged.
- Mode fill rules:
  - SLL fills with zeros from the LSB side.
  - SRL fills with zeros from the MSB side.
  - SRA fills with the operand's original MSB. A per-step arithmetic shift preserves this automatically.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- DONE: out_result and out_valid hold until out_ready=1. On out_ready=1 the next state is IDLE; out_valid drops next cycle and out_result keeps its last value.
- flush=1 in any state: next state is IDLE and out_valid=0 next cycle; the operation is discarded. flush beats in_valid in the same cycle, so nothing is accepted that cycle.
- rst takes priority over flush. Reset mid-operation behaves exactly like the reset state.
- in_mode, in_operand and in_shamt changing while BUSY have no effect.

Decomposition:
- Shared package iter_shifter_pkg holds:
  - mode encodings MODE_SLL=2'd0, MODE_SRL=2'd1, MODE_SRA=2'd2, MODE_ROR=2'd3;
  - state encodings ST_IDLE, ST_BUSY, ST_DONE.
- One combinational sub-module, shift_step, with parameters WIDTH and STEP.
  - Inputs: data, amount (0..STEP), mode.
  - Output: data shifted by amount in that mode.
  - iter_shifter instantiates it once. The FSM, counters and handshake stay in the top module.

Test Plan (WIDTH=32, STEP=8):
1. SLL, operand 0x0000_0001, shamt 2 -> out_result 0x0000_0004; out_valid 1 cycle after accept; in_ready=0 until handshake.
2. SRA, operand 0x8000_0000, shamt 31 -> 0xFFFF_FFFF after 4 BUSY cycles. SRL with the same inputs -> 0x0000_0001, also after 4 cycles.
3. ROR, operand 0x1234_5678, shamt 8 -> 0x7812_3456 in 1 cycle. ROR with shamt 20 -> 0x4567_8123 in 3 cycles.
4. SRL, operand 0xDEAD_BEEF, shamt 0 -> 0xDEAD_BEEF in 1 cycle. Back-to-back: the second request is accepted the cycle after the out handshake.
5. Backpressure: out_ready held low 3 cycles after out_valid -> out_result stable, busy=1, in_ready=0; out_ready=1 -> IDLE next cycle.
6. flush (and separately rst) asserted on the 2nd BUSY cycle of a shamt-24 SLL -> out_valid never asserts; in_ready=1 next cycle. A following request, SLL 0x1 by 4, returns 0x10 correctly.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// ---------------------------------------------------------------------------
// iter_shifter_pkg : shared mode and state encodings for the iterative shifter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iter_shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRL = 2'd1;
  localparam logic [1:0] MODE_SRA = 2'd2;
  localparam logic [1:0] MODE_ROR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step : single-cycle shift of up to STEP positions in one of four modes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  localparam int AMT_W = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int RW = $clog2(WIDTH) + 1;

  logic [RW-1:0]    w_rev_amt;
  logic [WIDTH-1:0] w_ror;

  // A zero amount gives a complementary shift of WIDTH, which yields zero
  assign w_rev_amt = RW'(WIDTH) - RW'(amount_i);
  assign w_ror     = (data_i >> amount_i) | (data_i << w_rev_amt);

  always_comb begin
    data_o = w_ror;
    case (mode_i)
      MODE_SLL: data_o = data_i << amount_i;
      MODE_SRL: data_o = data_i >> amount_i;
      MODE_SRA: data_o = $signed(data_i) >>> amount_i;
      default:  data_o = w_ror;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iter_shifter.sv
// ---------------------------------------------------------------------------
// iter_shifter : multi-cycle SLL/SRL/SRA/ROR unit, at most STEP bits per cycle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [WIDTH-1:0]   in_operand,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               busy
);

  localparam int AMT_W = $clog2(STEP) + 1;
  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W + 1)'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  logic [SHAMT_W:0]   w_rem_ext;
  logic [SHAMT_W:0]   w_step_ext;
  logic [SHAMT_W:0]   w_rem_next;
  logic [AMT_W-1:0]   w_step;
  logic [WIDTH-1:0]   w_shifted;

  // One extra bit so STEP==WIDTH still compares correctly against remaining
  assign w_rem_ext  = {1'b0, rem_q};
  assign w_step_ext = (w_rem_ext < STEP_EXT) ? w_rem_ext : STEP_EXT;
  assign w_step     = w_step_ext[AMT_W-1:0];
  assign w_rem_next = w_rem_ext - w_step_ext;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i   (work_q),
    .amount_i (w_step),
    .mode_i   (mode_q),
    .data_o   (w_shifted)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          work_d  = in_operand;
          mode_d  = in_mode;
          rem_d   = in_shamt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d = w_shifted;
        rem_d  = w_rem_next[SHAMT_W-1:0];
        if (w_rem_next == '0 && !flush) begin
          result_d = w_shifted;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      result_q <= '0;
      mode_q   <= MODE_SLL;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_BUSY) || (state_q == ST_DONE);
  assign out_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
// ---------------------------------------------------------------------------
// tb_iter_shifter : scoreboard bench with directed cases and random traffic
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iter_shifter;

  localparam int WIDTH   = 32;
  localparam int STEP    = 8;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, in_ready;
  logic [1:0]         in_mode;
  logic [WIDTH-1:0]   in_operand, out_result;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid, out_ready, busy;

  iter_shifter #(.WIDTH(WIDTH), .STEP(STEP), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_operand (in_operand),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_ready = 1'b0;
  bit   ready_val  = 1'b1;
  int   last_accept = 0;
  int   last_hs = 0;

  // Bit-by-bit reference: each result bit is located in the original operand
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] op, input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (m)
        2'd0:    r[i] = (i >= s) ? op[i-s] : 1'b0;
        2'd1:    r[i] = (i + s < 32) ? op[i+s] : 1'b0;
        2'd2:    r[i] = (i + s < 32) ? op[i+s] : op[31];
        default: r[i] = op[(i+s)%32];
      endcase
    end
    return r;
  endfunction

  function automatic int lat(input int s);
    return (s == 0) ? 1 : (s + STEP - 1) / STEP;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [1:0] m, input logic [31:0] op, input int s, input string tag);
    int w = 0;
    exp_t e;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 200) begin
        chk({"accept_timeout ", tag}, 32'd0, 32'd1);
        return;
      end
    end
    in_valid   = 1'b1;
    flush      = 1'b0;
    in_mode    = m;
    in_operand = op;
    in_shamt   = SHAMT_W'(s);
    e.res = model(m, op, s);
    e.due = cyc + 1 + lat(s);
    e.tag = tag;
    sb.push_back(e);
    last_accept = cyc + 1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_mode    = 2'($urandom);
    in_operand = $urandom;
    in_shamt   = SHAMT_W'($urandom);
    chk({"busy_after_accept ", tag}, {30'd0, busy, in_ready}, 32'd2);
  endtask

  // Abort on the second BUSY cycle using flush or rst
  task automatic abort(input logic [1:0] m, input logic [31:0] op, input int s, input bit use_rst);
    send(m, op, s, "abort");
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    in_valid = 1'b1;
    if (sb.size() > 0 && out_valid !== 1'b1) void'(sb.pop_back());
    @(negedge clk);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk(use_rst ? "idle_after_rst" : "idle_after_flush",
        {29'd0, in_ready, out_valid, busy}, 32'd4);
    if (use_rst) chk("result_cleared_by_rst", out_result, 32'd0);
  endtask

  // Monitor: compares every new result against the scoreboard and owns out_ready
  initial begin
    logic        prev_v  = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] held    = '0;
    exp_t        e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_hs) begin
        chk("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        chk("result_kept_after_handshake", out_result, held);
      end
      if (out_valid === 1'b1) begin
        chk("handshake_flags_in_done", {30'd0, in_ready, busy}, 32'd1);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %h expected none (cycle %0d)", out_result, cyc);
          end else begin
            e = sb.pop_front();
            chk({"result ", e.tag}, out_result, e.res);
            chk({"latency ", e.tag}, cyc, e.due);
          end
          held = out_result;
        end else begin
          chk("result_stable", out_result, held);
        end
      end
      prev_v    = (out_valid === 1'b1);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
      prev_hs   = prev_v && out_ready;
      if (prev_hs) last_hs = cyc + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_mode    = 2'd0;
    in_operand = '0;
    in_shamt   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("reset_result", out_result, 32'd0);

    // flush wins over in_valid while idle
    in_valid   = 1'b1;
    flush      = 1'b1;
    in_operand = 32'hFFFF_0000;
    in_shamt   = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_beats_valid", {30'd0, in_ready, busy}, 32'd2);

    send(2'd0, 32'h0000_0001, 2,  "sll_1_by_2");
    send(2'd2, 32'h8000_0000, 31, "sra_msb_by_31");
    send(2'd1, 32'h8000_0000, 31, "srl_msb_by_31");
    send(2'd3, 32'h1234_5678, 8,  "ror_by_8");
    send(2'd3, 32'h1234_5678, 20, "ror_by_20");
    send(2'd1, 32'hDEAD_BEEF, 0,  "srl_by_0");
    send(2'd0, 32'h0000_00F0, 1,  "sll_back_to_back");
    chk("back_to_back_accept", last_accept, last_hs + 1);

    // Backpressure: hold out_ready low for three cycles of valid
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    ready_val = 1'b0;
    send(2'd2, 32'h7000_0001, 9, "sra_backpressure");
    w = 0;
    while (out_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    repeat (3) begin
      @(negedge clk);
      chk("bp_held_result", out_result, 32'h0038_0000);
    end
    ready_val = 1'b1;

    abort(2'd0, 32'h0000_0001, 24, 1'b0);
    send(2'd0, 32'h0000_0001, 4, "sll_after_flush");
    abort(2'd0, 32'h0000_0001, 24, 1'b1);
    send(2'd0, 32'h0000_0001, 4, "sll_after_rst");

    rand_ready = 1'b1;
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        abort(2'($urandom), $urandom, $urandom_range(0, 31), 1'b0);
      else
        send(2'($urandom), $urandom, $urandom_range(0, 31), "random");
    end

    w = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && w < 500) begin @(negedge clk); w++; end
    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
